mem_bus_slave: RTL and testbench
================================

# mem_bus_slave

Memory-module responder on the system bus that the `cpu` master drives. It decodes `-DW`/`-DR` transfers for one configured memory block (NB) and a word range, and performs the access on an internal synchronous RAM. It answers with `-OK`, plus `-PE` when parity is compiled in. Addresses outside its range get no answer, so the CPU's no-memory timeout logic sees a missing module.

## Interface
Parameters:
- `NB`, 4'd0: memory block number this module serves.
- `ADDR_W`, 12: implemented words = 2**ADDR_W, range 1..16.
- `WAIT_CYC`, 2: access cycles between request sample and `-OK`, range 1..15.

Ports (bus signals active-low, bit 0 = MSB):
- `__clk` in 1: system clock.
- `clm_` in 1: asynchronous, active-low reset.
- `dmcl_` in 1: bus master clear, synchronous abort.
- `dw_` in 1: write strobe.
- `dr_` in 1: read strobe.
- `dnb_` in [0:3]: block number.
- `dad_` in [0:15]: word address.
- `ddt_` in [0:15]: write data.
- `rok_` out 1: transfer acknowledge.
- `rpe_` out 1: read parity error.
- `rdt_` out [0:15]: read data, all ones when not driving.

## Operation
- Decode: `hit` = (~`dnb_` == NB) and (~`dad_`[0:15-ADDR_W] == 0). The word index is the low ADDR_W bits of ~`dad_`.
- The FSM has four states: IDLE, WAIT, ACK, HOLD.
- **IDLE**
  - Exactly one of `dw_`/`dr_` low and `hit` → latch op, index and ~`ddt_`; load the counter with WAIT_CYC-1; go to WAIT.
  - Both strobes low, or `!hit` → stay in IDLE, no response.
- **WAIT**
  - Counter decrements each cycle.
  - At 0: a write commits the latched data to RAM; a read issues a RAM read. Go to ACK.
  - Latched strobe released early → IDLE. No write is committed and no output changes.
- **ACK**
  - Read: `rdt_` = ~data is driven; `rok_` stays high this cycle. Go to HOLD.
  - Write: go to HOLD.
- **HOLD**
  - `rok_`=0. For a read, `rdt_` is held and `rpe_` is valid (PARITY_EN).
  - Latched strobe goes high → `rok_`=1 and `rdt_`=FFFF next edge; go to IDLE.
- A new request is accepted only from IDLE, one cycle after release at the earliest.
- `dmcl_`=0 in any state → IDLE next edge, all outputs high. RAM contents are kept, and a write not yet committed is dropped.
- RAM contents are undefined after power-up and are not cleared by reset.

## Timing
- `clm_`=0 → immediately: state IDLE, `rok_`=1, `rpe_`=1, `rdt_`=16'hFFFF.
- Cycle numbering (request sampled at edge 0):
  - Write: `rok_` falls after edge WAIT_CYC+1.
  - Read: `rdt_` is valid after edge WAIT_CYC+1; `rok_` falls one edge later.
- Read data is stable at least one cycle before `rok_` falls, and for as long as `rok_` is low.
- `rok_` rises on the first edge after the strobe is sampled high. `rdt_` goes to FFFF on that same edge.
- Inputs are treated as synchronous to `__clk`; the bus wrapper upstream owns any synchronisation.

## Configuration
- `MEM_BUS_SLAVE_PARITY_EN` defined:
  - The RAM is 17 bits wide and stores even parity of the data on every write.
  - On a read with a mismatch, `rpe_`=0 for the whole HOLD phase, alongside `rok_`=0.
  - Adds input `pe_inj` (1 bit). A write with `pe_inj`=1 stores inverted parity.
- Not defined: the RAM is 16 bits wide, `rpe_` is tied to 1, and there is no `pe_inj` port.

## Structure
- Package `mem_bus_pkg`:
  - state enum (IDLE/WAIT/ACK/HOLD);
  - `DATA_W`=16;
  - `NB_W`=4;
  - the `par16` function.
- Sub-module `mem_bus_ram`: single-port synchronous RAM with parameters ADDR_W and width, one write enable and registered read.

## Test plan
- Write then read: write 16'h1234 to NB=0, addr 0x0005, then read it back → `rok_` low after 3 edges (WAIT_CYC=2); `rdt_`=~16'h1234 while `rok_`=0.
- No answer: read with `dnb_`=~4'd1, or addr 0x1000 (ADDR_W=12) → `rok_` and `rdt_` stay high for 50 cycles.
- Early release: `dw_` low at edge 0 with 16'hBEEF, released at edge 1 → no `rok_`; a later read of that address returns the old value.
- Abort: `dmcl_` pulsed during HOLD of a read → `rok_`=1 and `rdt_`=FFFF next edge; the FSM accepts a new read at the following edge.
- Async reset: `clm_` asserted mid-WAIT between edges → outputs high immediately; after release the FSM is idle and a pending write of 16'h00FF is not stored.
- Parity (macro on): write 16'hA5A5 with `pe_inj`=1, then read → `rpe_`=0 together with `rok_`=0. A clean write gives `rpe_`=1.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared state type, widths and parity helper for the memory bus slave.
// Latency: none (types and a pure function only).
// Backpressure: none.
package mem_bus_pkg;

    localparam int DATA_W = 16;
    localparam int NB_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_HOLD
    } state_t;

    // Even parity bit: makes the total number of ones across data+bit even.
    function automatic logic par16(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mem_bus_ram.sv
// Single-port synchronous RAM with one write enable and a registered read port.
// Latency: read data appears one clock after the address is presented.
// Backpressure: none; accepts an access every cycle.
module mem_bus_ram #(
    parameter int ADDR_W = 12,
    parameter int WIDTH  = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [2**ADDR_W];
    logic [WIDTH-1:0] rdata_q;

    // No reset on purpose: contents survive bus clears and system resets.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_bus_slave.sv
// Memory-module responder for -DW/-DR transfers on one block/word range (MEM_BUS_SLAVE_PARITY_EN adds parity).
// Latency: write ack WAIT_CYC+1 edges after the request; read data WAIT_CYC+1, read ack WAIT_CYC+2.
// Backpressure: master holds its strobe until -OK; releasing it early aborts, and misses get no answer.
module mem_bus_slave
    import mem_bus_pkg::*;
#(
    parameter logic [NB_W-1:0] NB       = 4'd0,
    parameter int              ADDR_W   = 12,
    parameter int              WAIT_CYC = 2
) (
    input  logic        __clk,
    input  logic        clm_,
    input  logic        dmcl_,
    input  logic        dw_,
    input  logic        dr_,
    input  logic [0:3]  dnb_,
    input  logic [0:15] dad_,
    input  logic [0:15] ddt_,
`ifdef MEM_BUS_SLAVE_PARITY_EN
    input  logic        pe_inj,
`endif
    output logic        rok_,
    output logic        rpe_,
    output logic [0:15] rdt_
);

`ifdef MEM_BUS_SLAVE_PARITY_EN
    localparam int RAM_W = DATA_W + 1;
`else
    localparam int RAM_W = DATA_W;
`endif
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

    state_t            state_q, state_d;
    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rok_q, rok_d;
    logic [DATA_W-1:0] rdt_q, rdt_d;

    logic              ram_we;
    logic [RAM_W-1:0]  ram_wdata, ram_rdata;
    logic [DATA_W-1:0] addr_n;
    logic              hit, req_wr, req_rd, held;

    assign addr_n = ~dad_;
    assign hit    = (~dnb_ == NB) && ((addr_n >> ADDR_W) == '0);
    assign req_wr = !dw_ && dr_;
    assign req_rd = !dr_ && dw_;
    // The strobe that opened the current transfer must stay asserted throughout.
    assign held   = op_wr_q ? !dw_ : !dr_;

`ifdef MEM_BUS_SLAVE_PARITY_EN
    logic pinj_q, pinj_d;
    logic perr_q, perr_d;
    logic rpe_q, rpe_d;

    assign ram_wdata = {par16(wdat_q) ^ pinj_q, wdat_q};
    assign rpe_      = rpe_q;
`else
    assign ram_wdata = wdat_q;
    assign rpe_      = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdat_d  = wdat_q;
        cnt_d   = cnt_q;
        rok_d   = 1'b1;
        rdt_d   = '1;
        ram_we  = 1'b0;
`ifdef MEM_BUS_SLAVE_PARITY_EN
        pinj_d  = pinj_q;
        perr_d  = perr_q;
        rpe_d   = 1'b1;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if ((req_wr || req_rd) && hit) begin
                    state_d = ST_WAIT;
                    op_wr_d = req_wr;
                    idx_d   = addr_n[ADDR_W-1:0];
                    wdat_d  = ~ddt_;
                    cnt_d   = CNT_INIT;
`ifdef MEM_BUS_SLAVE_PARITY_EN
                    pinj_d  = pe_inj;
`endif
                end
            end
            ST_WAIT: begin
                if (!held) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    ram_we  = op_wr_q;
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_HOLD;
                if (op_wr_q) begin
                    rok_d = 1'b0;
                end else begin
                    rdt_d = ~ram_rdata[DATA_W-1:0];
`ifdef MEM_BUS_SLAVE_PARITY_EN
                    perr_d = par16(ram_rdata[DATA_W-1:0]) != ram_rdata[DATA_W];
`endif
                end
            end
            ST_HOLD: begin
                if (!held) begin
                    state_d = ST_IDLE;
                end else begin
                    rok_d = 1'b0;
                    if (!op_wr_q) begin
                        rdt_d = rdt_q;
`ifdef MEM_BUS_SLAVE_PARITY_EN
                        rpe_d = !perr_q;
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus master clear wins over everything; an uncommitted write is simply lost.
        if (!dmcl_) begin
            state_d = ST_IDLE;
            rok_d   = 1'b1;
            rdt_d   = '1;
            ram_we  = 1'b0;
`ifdef MEM_BUS_SLAVE_PARITY_EN
            rpe_d   = 1'b1;
`endif
        end
    end

    always_ff @(posedge __clk or negedge clm_) begin
        if (!clm_) begin
            state_q <= ST_IDLE;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdat_q  <= '0;
            cnt_q   <= '0;
            rok_q   <= 1'b1;
            rdt_q   <= '1;
        end else begin
            state_q <= state_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdat_q  <= wdat_d;
            cnt_q   <= cnt_d;
            rok_q   <= rok_d;
            rdt_q   <= rdt_d;
        end
    end

`ifdef MEM_BUS_SLAVE_PARITY_EN
    always_ff @(posedge __clk or negedge clm_) begin
        if (!clm_) begin
            pinj_q <= 1'b0;
            perr_q <= 1'b0;
            rpe_q  <= 1'b1;
        end else begin
            pinj_q <= pinj_d;
            perr_q <= perr_d;
            rpe_q  <= rpe_d;
        end
    end
`endif

    assign rok_ = rok_q;
    assign rdt_ = rdt_q;

    mem_bus_ram #(
        .ADDR_W (ADDR_W),
        .WIDTH  (RAM_W)
    ) u_ram (
        .clk   (__clk),
        .we    (ram_we),
        .addr  (idx_q),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_bus_slave.sv
// Bench for mem_bus_slave: directed scenarios plus random traffic against a word-array model.
// Drives at posedge+1, samples at posedge+1 after each edge.
module tb_mem_bus_slave;

    localparam logic [3:0] NB       = 4'd0;
    localparam int         ADDR_W   = 12;
    localparam int         WAIT_CYC = 2;
    localparam int         WR_LAT   = WAIT_CYC + 1;
    localparam int         RD_LAT   = WAIT_CYC + 2;

    logic        clk   = 1'b0;
    logic        clm_  = 1'b1;
    logic        dmcl_ = 1'b1;
    logic        dw_   = 1'b1;
    logic        dr_   = 1'b1;
    logic [0:3]  dnb_  = 4'hF;
    logic [0:15] dad_  = 16'hFFFF;
    logic [0:15] ddt_  = 16'hFFFF;
    logic        rok_;
    logic        rpe_;
    logic [0:15] rdt_;
`ifdef MEM_BUS_SLAVE_PARITY_EN
    logic        pe_inj = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] ref_mem [int];

    int          r_lat, r_dv;
    logic [15:0] r_rd, r_hold, r_rdt_rel;
    logic        r_rpe, r_rpe_hold, r_rok_hold, r_rok_rel;

    always #5 clk = ~clk;

    mem_bus_slave #(
        .NB       (NB),
        .ADDR_W   (ADDR_W),
        .WAIT_CYC (WAIT_CYC)
    ) dut (
        .__clk (clk),
        .clm_  (clm_),
        .dmcl_ (dmcl_),
        .dw_   (dw_),
        .dr_   (dr_),
        .dnb_  (dnb_),
        .dad_  (dad_),
        .ddt_  (ddt_),
`ifdef MEM_BUS_SLAVE_PARITY_EN
        .pe_inj(pe_inj),
`endif
        .rok_  (rok_),
        .rpe_  (rpe_),
        .rdt_  (rdt_)
    );

    // Edge index n counts from the first edge after the call (edge 0 samples the request).
    task automatic wait_ack(input int budget);
        r_lat = -1; r_dv = -1; r_rd = 16'h0000; r_rpe = 1'b1;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk); #1;
            if (r_dv < 0 && rdt_ !== 16'hFFFF) r_dv = n;
            if (rok_ === 1'b0) begin
                r_lat = n; r_rd = ~rdt_; r_rpe = rpe_;
                break;
            end
        end
    endtask

    task automatic xfer(input bit wr, input logic [3:0] nb, input logic [15:0] addr,
                        input logic [15:0] data, input int budget);
        dnb_ = ~nb; dad_ = ~addr; ddt_ = ~data;
        dw_ = !wr; dr_ = wr;
        wait_ack(budget);
        r_rok_hold = 1'b1; r_hold = 16'h0000; r_rpe_hold = 1'b1;
        if (r_lat >= 0) begin
            @(posedge clk); #1;
            r_rok_hold = rok_; r_hold = ~rdt_; r_rpe_hold = rpe_;
        end
        dw_ = 1'b1; dr_ = 1'b1;
        @(posedge clk); #1;
        r_rok_rel = rok_; r_rdt_rel = rdt_;
    endtask

    task automatic test_reset();
        #3; clm_ = 1'b0; #1;
        checks++; if (rok_ !== 1'b1) begin errors++; $display("FAIL reset_rok: got %b expected 1", rok_); end
        checks++; if (rpe_ !== 1'b1) begin errors++; $display("FAIL reset_rpe: got %b expected 1", rpe_); end
        checks++; if (rdt_ !== 16'hFFFF) begin errors++; $display("FAIL reset_rdt: got %h expected ffff", rdt_); end
        repeat (2) @(posedge clk);
        #1; clm_ = 1'b1;
        wait_ack(5);
        checks++; if (r_lat != -1) begin errors++; $display("FAIL reset_idle: ack at edge %0d expected none", r_lat); end
    endtask

    task automatic test_write_read();
        xfer(1'b1, NB, 16'h0005, 16'h1234, 12);
        ref_mem[5] = 16'h1234;
        checks++; if (r_lat != WR_LAT) begin errors++; $display("FAIL wr_lat: got %0d expected %0d", r_lat, WR_LAT); end
        checks++; if (r_dv != -1) begin errors++; $display("FAIL wr_rdt_idle: rdt driven at edge %0d expected never", r_dv); end
        checks++; if (r_rok_rel !== 1'b1) begin errors++; $display("FAIL wr_release: rok %b expected 1", r_rok_rel); end
        xfer(1'b0, NB, 16'h0005, 16'h0000, 12);
        checks++; if (r_lat != RD_LAT) begin errors++; $display("FAIL rd_lat: got %0d expected %0d", r_lat, RD_LAT); end
        checks++; if (r_dv != WR_LAT) begin errors++; $display("FAIL rd_data_edge: got %0d expected %0d", r_dv, WR_LAT); end
        checks++; if (r_rd !== 16'h1234) begin errors++; $display("FAIL rd_data: got %h expected 1234", r_rd); end
        checks++; if (r_rok_hold !== 1'b0 || r_hold !== 16'h1234) begin errors++; $display("FAIL rd_hold: rok %b data %h expected 0 1234", r_rok_hold, r_hold); end
        checks++; if (r_rok_rel !== 1'b1 || r_rdt_rel !== 16'hFFFF) begin errors++; $display("FAIL rd_release: rok %b rdt %h expected 1 ffff", r_rok_rel, r_rdt_rel); end
    endtask

    task automatic test_no_answer();
        xfer(1'b0, 4'd1, 16'h0005, 16'h0000, 50);
        checks++; if (r_lat != -1 || r_dv != -1) begin errors++; $display("FAIL miss_nb: ack %0d drive %0d expected -1 -1", r_lat, r_dv); end
        xfer(1'b0, NB, 16'h1000, 16'h0000, 50);
        checks++; if (r_lat != -1 || r_dv != -1) begin errors++; $display("FAIL miss_addr: ack %0d drive %0d expected -1 -1", r_lat, r_dv); end
        dnb_ = ~NB; dad_ = ~16'h0005; dw_ = 1'b0; dr_ = 1'b0;
        wait_ack(20);
        checks++; if (r_lat != -1 || r_dv != -1) begin errors++; $display("FAIL both_strobes: ack %0d drive %0d expected -1 -1", r_lat, r_dv); end
        dw_ = 1'b1; dr_ = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_early_release();
        dnb_ = ~NB; dad_ = ~16'h0005; ddt_ = ~16'hBEEF; dw_ = 1'b0;
        @(posedge clk); #1;
        dw_ = 1'b1;
        wait_ack(10);
        checks++; if (r_lat != -1) begin errors++; $display("FAIL early_rel_ack: ack at %0d expected none", r_lat); end
        xfer(1'b0, NB, 16'h0005, 16'h0000, 12);
        checks++; if (r_lat != RD_LAT || r_rd !== ref_mem[5]) begin errors++; $display("FAIL early_rel_data: lat %0d data %h expected %0d %h", r_lat, r_rd, RD_LAT, ref_mem[5]); end
    endtask

    task automatic test_abort();
        dnb_ = ~NB; dad_ = ~16'h0005; dr_ = 1'b0;
        wait_ack(12);
        checks++; if (r_lat != RD_LAT) begin errors++; $display("FAIL abort_first_lat: got %0d expected %0d", r_lat, RD_LAT); end
        dmcl_ = 1'b0;
        @(posedge clk); #1;
        checks++; if (rok_ !== 1'b1 || rdt_ !== 16'hFFFF) begin errors++; $display("FAIL abort_outputs: rok %b rdt %h expected 1 ffff", rok_, rdt_); end
        dmcl_ = 1'b1;
        wait_ack(12);
        checks++; if (r_lat != RD_LAT || r_rd !== ref_mem[5]) begin errors++; $display("FAIL abort_reread: lat %0d data %h expected %0d %h", r_lat, r_rd, RD_LAT, ref_mem[5]); end
        dr_ = 1'b1;
        @(posedge clk); #1;
        checks++; if (rok_ !== 1'b1) begin errors++; $display("FAIL abort_release: rok %b expected 1", rok_); end
    endtask

    task automatic test_async_reset();
        xfer(1'b1, NB, 16'h0007, 16'h1111, 12);
        ref_mem[7] = 16'h1111;
        dnb_ = ~NB; dad_ = ~16'h0007; dr_ = 1'b0;
        wait_ack(12);
        #2; clm_ = 1'b0; #1;
        checks++; if (rok_ !== 1'b1 || rdt_ !== 16'hFFFF) begin errors++; $display("FAIL arst_hold: rok %b rdt %h expected 1 ffff", rok_, rdt_); end
        dr_ = 1'b1;
        @(posedge clk); #1; clm_ = 1'b1;
        ddt_ = ~16'h00FF; dw_ = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        clm_ = 1'b0; #1;
        checks++; if (rok_ !== 1'b1 || rdt_ !== 16'hFFFF) begin errors++; $display("FAIL arst_wait: rok %b rdt %h expected 1 ffff", rok_, rdt_); end
        dw_ = 1'b1;
        @(posedge clk); #1; clm_ = 1'b1;
        wait_ack(8);
        checks++; if (r_lat != -1) begin errors++; $display("FAIL arst_idle: ack at %0d expected none", r_lat); end
        xfer(1'b0, NB, 16'h0007, 16'h0000, 12);
        checks++; if (r_rd !== 16'h1111) begin errors++; $display("FAIL arst_dropped_write: got %h expected 1111", r_rd); end
    endtask

    // Random back-to-back traffic: the next request follows the release edge directly.
    task automatic test_back_to_back();
        logic [15:0] addrs [6];
        logic [15:0] a, d;
        logic [3:0]  nb;
        int          k, kind;
        for (int i = 0; i < 6; i++) addrs[i] = 16'($urandom_range(0, (1 << ADDR_W) - 1));
        for (int t = 0; t < 40; t++) begin
            k = $urandom_range(0, 5);
            kind = $urandom_range(0, 9);
            a = addrs[k];
            if (kind < 4 || (kind < 8 && !ref_mem.exists(int'(a)))) begin
                d = 16'($urandom_range(1, 16'hFFFF));
                xfer(1'b1, NB, a, d, 12);
                ref_mem[int'(a)] = d;
                checks++; if (r_lat != WR_LAT || r_rok_rel !== 1'b1) begin errors++; $display("FAIL rnd_wr: addr %h lat %0d rel %b expected %0d 1", a, r_lat, r_rok_rel, WR_LAT); end
            end else if (kind < 8) begin
                xfer(1'b0, NB, a, 16'h0000, 12);
                checks++;
                if (r_lat != RD_LAT || r_dv != WR_LAT || r_rd !== ref_mem[int'(a)] || r_hold !== ref_mem[int'(a)] || r_rpe !== 1'b1 || r_rdt_rel !== 16'hFFFF) begin
                    errors++;
                    $display("FAIL rnd_rd: addr %h lat %0d dv %0d data %h hold %h rpe %b expected %0d %0d %h %h 1",
                             a, r_lat, r_dv, r_rd, r_hold, r_rpe, RD_LAT, WR_LAT, ref_mem[int'(a)], ref_mem[int'(a)]);
                end
            end else begin
                nb = NB;
                if (kind == 8) nb = NB ^ 4'($urandom_range(1, 15));
                else a = 16'($urandom_range(1 << ADDR_W, 16'hFFFF));
                xfer(1'b0, nb, a, 16'h0000, 12);
                checks++; if (r_lat != -1 || r_dv != -1) begin errors++; $display("FAIL rnd_miss: nb %0d addr %h ack %0d drive %0d expected -1 -1", nb, a, r_lat, r_dv); end
            end
        end
    endtask

`ifdef MEM_BUS_SLAVE_PARITY_EN
    task automatic test_parity();
        pe_inj = 1'b1;
        xfer(1'b1, NB, 16'h0009, 16'hA5A5, 12);
        pe_inj = 1'b0;
        xfer(1'b0, NB, 16'h0009, 16'h0000, 12);
        checks++; if (r_lat != RD_LAT || r_rd !== 16'hA5A5) begin errors++; $display("FAIL par_data: lat %0d data %h expected %0d a5a5", r_lat, r_rd, RD_LAT); end
        checks++; if (r_rpe !== 1'b0 || r_rpe_hold !== 1'b0) begin errors++; $display("FAIL par_err: rpe %b hold %b expected 0 0", r_rpe, r_rpe_hold); end
        xfer(1'b1, NB, 16'h000A, 16'hA5A5, 12);
        xfer(1'b0, NB, 16'h000A, 16'h0000, 12);
        checks++; if (r_rpe !== 1'b1 || r_rd !== 16'hA5A5) begin errors++; $display("FAIL par_clean: rpe %b data %h expected 1 a5a5", r_rpe, r_rd); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_no_answer();
        test_early_release();
        test_abort();
        test_async_reset();
        test_back_to_back();
`ifdef MEM_BUS_SLAVE_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
